// File: rtl/fp16_pkg.sv
// Shared widths, field positions and FSM encoding for the binary16 normalize/pack stage.
package fp16_pkg;

  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int BIAS   = 15;
  localparam int MANT_W = FRAC_W + 4;

  localparam logic [EXP_W-1:0] EXP_INF = 5'h1F;
  // Largest finite exponent plus one; anything at or above this saturates to Inf.
  localparam logic [EXP_W:0]   EXP_MAX = (EXP_W+1)'(2*BIAS + 1);

  // raw_mant field positions
  localparam int RM_CARRY  = 13;
  localparam int RM_HIDDEN = 12;
  localparam int RM_LSB    = 2;
  localparam int RM_GUARD  = 1;
  localparam int RM_STICKY = 0;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SHIFT,
    ROUND,
    DONE
  } state_t;

endpackage

// File: rtl/fp16_round.sv
// Combinational mantissa rounder: RNE when FP_NORM_RNE_EN is defined, truncation otherwise.
module fp16_round
  import fp16_pkg::*;
(
  input  logic [FRAC_W:0] mant_i,
  input  logic            guard_i,
  input  logic            sticky_i,
  output logic [FRAC_W:0] mant_o,
  output logic            carry_o
);

  logic up;

`ifdef FP_NORM_RNE_EN
  assign up = guard_i & (sticky_i | mant_i[0]);
`else
  assign up = 1'b0 & (guard_i | sticky_i);
`endif

  assign {carry_o, mant_o} = {1'b0, mant_i} + {{(FRAC_W+1){1'b0}}, up};

endmodule

// File: rtl/fp16_normalize_pack.sv
// Iterative normalize/round/pack stage closing the binary16 adder datapath.
// Rounding mode selected by FP_NORM_RNE_EN (defined: RNE, undefined: truncate).
//
// state | meaning
// IDLE  | waiting for start, outputs hold last result
// PRE   | zero detect, absorb carry bit with one right shift
// SHIFT | one left shift per cycle until hidden bit set or exp==1
// ROUND | round, renormalize on carry-out, pack into result regs
// DONE  | ready pulse, result valid
module fp16_normalize_pack
  import fp16_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sign_in,
  input  logic [EXP_W-1:0]      exp_in,
  input  logic [MANT_W-1:0]     raw_mant,
  output logic [EXP_W+FRAC_W:0] result,
  output logic                  ready,
  output logic                  busy,
  output logic                  overflow,
  output logic                  underflow
);

  state_t                  state_q, state_d;
  logic                    sign_q, sign_d;
  logic [EXP_W:0]          exp_q, exp_d;
  logic [MANT_W-1:0]       mant_q, mant_d;
  logic                    zero_q, zero_d;
  logic                    ovf_q, ovf_d;
  logic [EXP_W+FRAC_W:0]   res_q, res_d;
  logic                    ovf_out_q, ovf_out_d;
  logic                    unf_out_q, unf_out_d;

  logic [FRAC_W:0]         rnd_mant, mant_r;
  logic                    rnd_carry;
  logic [EXP_W:0]          exp_r;

  fp16_round u_round (
    .mant_i   (mant_q[RM_HIDDEN:RM_LSB]),
    .guard_i  (mant_q[RM_GUARD]),
    .sticky_i (mant_q[RM_STICKY]),
    .mant_o   (rnd_mant),
    .carry_o  (rnd_carry)
  );

  assign mant_r = rnd_carry ? {1'b1, rnd_mant[FRAC_W:1]} : rnd_mant;
  assign exp_r  = exp_q + {{EXP_W{1'b0}}, rnd_carry};

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    mant_d    = mant_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    res_d     = res_q;
    ovf_out_d = ovf_out_q;
    unf_out_d = unf_out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sign_d  = sign_in;
          exp_d   = (exp_in == '0) ? (EXP_W+1)'(1) : {1'b0, exp_in};
          mant_d  = raw_mant;
          zero_d  = 1'b0;
          ovf_d   = (exp_in == EXP_INF);
          state_d = PRE;
        end
      end
      PRE: begin
        if (mant_q == '0) begin
          zero_d  = 1'b1;
          state_d = ROUND;
        end else begin
          if (mant_q[RM_CARRY]) begin
            mant_d = {1'b0, mant_q[RM_CARRY:RM_LSB], mant_q[RM_GUARD] | mant_q[RM_STICKY]};
            exp_d  = exp_q + (EXP_W+1)'(1);
            if (exp_q + (EXP_W+1)'(1) >= EXP_MAX) ovf_d = 1'b1;
          end
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!mant_q[RM_HIDDEN] && exp_q > (EXP_W+1)'(1)) begin
          mant_d = {mant_q[MANT_W-2:0], 1'b0};
          exp_d  = exp_q - (EXP_W+1)'(1);
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (zero_q) begin
          res_d     = {sign_q, {(EXP_W+FRAC_W){1'b0}}};
          ovf_out_d = 1'b0;
          unf_out_d = 1'b1;
        end else if (ovf_q || exp_r >= EXP_MAX) begin
          res_d     = {sign_q, EXP_INF, {FRAC_W{1'b0}}};
          ovf_out_d = 1'b1;
          unf_out_d = 1'b0;
        end else begin
          // A subnormal that rounds into the hidden bit picks up exp==1 here.
          res_d     = {sign_q, mant_r[FRAC_W] ? exp_r[EXP_W-1:0] : {EXP_W{1'b0}},
                       mant_r[FRAC_W-1:0]};
          ovf_out_d = 1'b0;
          unf_out_d = !mant_r[FRAC_W];
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      mant_q    <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      res_q     <= '0;
      ovf_out_q <= 1'b0;
      unf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      mant_q    <= mant_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      res_q     <= res_d;
      ovf_out_q <= ovf_out_d;
      unf_out_q <= unf_out_d;
    end
  end

  assign ready     = (state_q == DONE);
  assign busy      = (state_q == PRE) || (state_q == SHIFT) || (state_q == ROUND);
  assign result    = res_q;
  assign overflow  = ovf_out_q;
  assign underflow = unf_out_q;

endmodule

// File: tb/tb_fp16_normalize_pack.sv
// Scoreboard bench for fp16_normalize_pack; expectations follow FP_NORM_RNE_EN.
module tb_fp16_normalize_pack;

`ifdef FP_NORM_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sign_in = 1'b0;
  logic [4:0]  exp_in = '0;
  logic [13:0] raw_mant = '0;
  logic [15:0] result;
  logic        ready, busy, overflow, underflow;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    logic        unf;
    int          lat;   // -1: latency not checked
  } exp_t;

  typedef struct {
    logic        s;
    logic [4:0]  e;
    logic [13:0] m;
    exp_t        x;
  } vec_t;

  exp_t sb[$];

  fp16_normalize_pack dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .raw_mant  (raw_mant),
    .result    (result),
    .ready     (ready),
    .busy      (busy),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic s, input logic [4:0] e_in, input logic [13:0] raw);
    exp_t r;
    int   e, m, keep, n, field;
    bit   ov;
    if (raw == 14'd0) begin
      r.res = {s, 15'd0}; r.ovf = 1'b0; r.unf = 1'b1; r.lat = -1;
      return r;
    end
    e  = (e_in == 5'd0) ? 1 : int'(e_in);
    m  = int'(raw);
    n  = 0;
    ov = (e >= 31);
    if (m >= 8192) begin
      m = (m >> 1) | (m & 1);
      e = e + 1;
    end
    ov = ov || (e >= 31);
    while (m < 4096 && e > 1) begin
      m = m << 1; e = e - 1; n = n + 1;
    end
    keep = m >> 2;
    if (RNE && ((m >> 1) & 1) == 1 && ((m & 1) == 1 || (keep & 1) == 1)) keep = keep + 1;
    if (keep >= 2048) begin
      keep = keep >> 1; e = e + 1;
    end
    ov = ov || (e >= 31);
    if (ov) begin
      r.res = {s, 5'h1F, 10'h0}; r.ovf = 1'b1; r.unf = 1'b0;
    end else begin
      field = (keep >= 1024) ? e : 0;
      r.res = {s, 5'(field), 10'(keep)};
      r.ovf = 1'b0;
      r.unf = (field == 0);
    end
    r.lat = 4 + n;
    return r;
  endfunction

  task automatic drive_op(input logic s, input logic [4:0] e, input logic [13:0] m,
                          input exp_t x, input bit push);
    if (push) sb.push_back(x);
    @(negedge clk);
    sign_in = s; exp_in = e; raw_mant = m; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns in the ready cycle (at its negedge), or after the budget expires.
  task automatic wait_ready(output int lat, output bit to);
    lat = 1;
    @(negedge clk);
    while (!ready && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    to = !ready;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({result, ready, busy, overflow, underflow} !== 20'd0) begin
      n_bad++;
      $display("FAIL reset outputs got res=%h rdy=%b busy=%b ovf=%b unf=%b want all 0",
               result, ready, busy, overflow, underflow);
    end
  endtask

  task automatic test_directed();
    vec_t v[$];
    exp_t e;
    int   lat;
    bit   to;
    v.push_back('{1'b0, 5'd15, 14'b01_0000000000_00, '{16'h3C00, 1'b0, 1'b0, 4}});
    v.push_back('{1'b0, 5'd15, 14'b10_0000000000_00, '{16'h4000, 1'b0, 1'b0, 4}});
    v.push_back('{1'b1, 5'd30, 14'b10_0000000000_00, '{16'hFC00, 1'b1, 1'b0, 4}});
    v.push_back('{1'b0, 5'd15, 14'b00_0100000000_00, '{16'h3400, 1'b0, 1'b0, 6}});
    v.push_back('{1'b0, 5'd2,  14'b00_0100000000_00, '{16'h0200, 1'b0, 1'b1, 5}});
    v.push_back('{1'b0, 5'd15, 14'b01_0000000001_10, '{RNE ? 16'h3C02 : 16'h3C01, 1'b0, 1'b0, 4}});
    v.push_back('{1'b0, 5'd15, 14'b01_0000000000_10, '{16'h3C00, 1'b0, 1'b0, 4}});
    v.push_back('{1'b1, 5'd15, 14'b00_0000000000_00, '{16'h8000, 1'b0, 1'b1, -1}});
    v.push_back('{1'b0, 5'd0,  14'b01_0000000000_00, '{16'h0400, 1'b0, 1'b0, 4}});
    v.push_back('{1'b0, 5'd15, 14'b01_1111111111_11, '{RNE ? 16'h4000 : 16'h3FFF, 1'b0, 1'b0, 4}});
    v.push_back('{1'b0, 5'd1,  14'b00_1111111111_11, '{RNE ? 16'h0400 : 16'h03FF, 1'b0, !RNE, 4}});
    v.push_back('{1'b0, 5'd31, 14'b01_0000000000_00, '{16'h7C00, 1'b1, 1'b0, 4}});
    foreach (v[i]) begin
      drive_op(v[i].s, v[i].e, v[i].m, v[i].x, 1'b1);
      wait_ready(lat, to);
      e = sb.pop_front();
      n_cmp++;
      if (to) begin
        n_bad++;
        $display("FAIL dir%0d ready: no pulse within budget", i);
      end else begin
        if ({result, overflow, underflow} !== {e.res, e.ovf, e.unf}) begin
          n_bad++;
          $display("FAIL dir%0d result/ovf/unf got %h/%b/%b want %h/%b/%b",
                   i, result, overflow, underflow, e.res, e.ovf, e.unf);
        end
        if (e.lat > 0) begin
          n_cmp++;
          if (lat != e.lat) begin
            n_bad++;
            $display("FAIL dir%0d latency got %0d want %0d", i, lat, e.lat);
          end
        end
        n_cmp++;
        if (busy !== 1'b0) begin
          n_bad++;
          $display("FAIL dir%0d busy in ready cycle got %b want 0", i, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (ready !== 1'b0) begin
          n_bad++;
          $display("FAIL dir%0d ready width got ready=%b one cycle later want 0", i, ready);
        end
      end
    end
  endtask

  task automatic test_random();
    exp_t e;
    int   lat;
    bit   to;
    logic s;
    logic [4:0] ex;
    logic [13:0] m;
    for (int i = 0; i < 40; i++) begin
      s  = 1'($urandom_range(0, 1));
      ex = 5'($urandom_range(0, 31));
      m  = 14'($urandom_range(0, 16383) >> $urandom_range(0, 12));
      drive_op(s, ex, m, model(s, ex, m), 1'b1);
      wait_ready(lat, to);
      e = sb.pop_front();
      n_cmp++;
      if (to) begin
        n_bad++;
        $display("FAIL rnd%0d ready: no pulse within budget", i);
      end else begin
        if ({result, overflow, underflow} !== {e.res, e.ovf, e.unf}) begin
          n_bad++;
          $display("FAIL rnd%0d s=%b e=%0d m=%h result/ovf/unf got %h/%b/%b want %h/%b/%b",
                   i, s, ex, m, result, overflow, underflow, e.res, e.ovf, e.unf);
        end
        if (e.lat > 0) begin
          n_cmp++;
          if (lat != e.lat) begin
            n_bad++;
            $display("FAIL rnd%0d latency got %0d want %0d", i, lat, e.lat);
          end
        end
      end
    end
  endtask

  task automatic test_start_while_busy();
    exp_t e;
    int   lat;
    bit   to, seen;
    drive_op(1'b0, 5'd15, 14'b00_0100000000_00, '{16'h3400, 1'b0, 1'b0, 6}, 1'b1);
    @(negedge clk);
    sign_in = 1'b1; exp_in = 5'd30; raw_mant = 14'b10_0000000000_00; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_ready(lat, to);
    lat = lat + 1;  // first negedge was consumed by the stray start
    e = sb.pop_front();
    n_cmp++;
    if (to) begin
      n_bad++;
      $display("FAIL busy_start ready: no pulse within budget");
    end else begin
      if ({result, overflow, underflow} !== {e.res, e.ovf, e.unf}) begin
        n_bad++;
        $display("FAIL busy_start result/ovf/unf got %h/%b/%b want %h/%b/%b",
                 result, overflow, underflow, e.res, e.ovf, e.unf);
      end
      n_cmp++;
      if (lat != e.lat) begin
        n_bad++;
        $display("FAIL busy_start latency got %0d want %0d", lat, e.lat);
      end
    end
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (ready || busy) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL busy_start extra activity got busy/ready after op want none");
    end
  endtask

  task automatic test_start_in_done();
    exp_t e;
    int   lat;
    bit   to, seen;
    drive_op(1'b0, 5'd15, 14'b01_0000000000_00, '{16'h3C00, 1'b0, 1'b0, 4}, 1'b1);
    wait_ready(lat, to);
    sign_in = 1'b1; exp_in = 5'd20; raw_mant = 14'b01_0000000000_00; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    e = sb.pop_front();
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (ready || busy) seen = 1'b1;
    end
    n_cmp++;
    if (to || seen) begin
      n_bad++;
      $display("FAIL done_start got timeout=%b activity=%b want 0/0", to, seen);
    end
    n_cmp++;
    if (result !== e.res) begin
      n_bad++;
      $display("FAIL done_start result got %h want %h", result, e.res);
    end
  endtask

  task automatic test_reset_mid_op();
    exp_t dummy;
    bit   seen;
    dummy = '{16'h0, 1'b0, 1'b0, -1};
    drive_op(1'b0, 5'd15, 14'h0004, dummy, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({result, ready, busy, overflow, underflow} !== 20'd0) begin
      n_bad++;
      $display("FAIL rst_mid outputs got res=%h rdy=%b busy=%b ovf=%b unf=%b want all 0",
               result, ready, busy, overflow, underflow);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (ready || busy) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL rst_mid aborted op got ready/busy after reset want none");
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    bit   to;
    logic s;
    logic [4:0] ex;
    logic [13:0] m;
    for (int i = 0; i < 6; i++) begin
      s  = 1'(i & 1);
      ex = 5'(3 + 4 * i);
      m  = 14'(14'h0100 << i) | 14'h0003;
      drive_op(s, ex, m, model(s, ex, m), 1'b1);
      wait_ready(lat, to);
      e = sb.pop_front();
      n_cmp++;
      if (to) begin
        n_bad++;
        $display("FAIL b2b%0d ready: no pulse within budget", i);
      end else if ({result, overflow, underflow, lat} !== {e.res, e.ovf, e.unf, e.lat}) begin
        n_bad++;
        $display("FAIL b2b%0d result/ovf/unf/lat got %h/%b/%b/%0d want %h/%b/%b/%0d",
                 i, result, overflow, underflow, lat, e.res, e.ovf, e.unf, e.lat);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_directed();
    test_random();
    test_start_while_busy();
    test_start_in_done();
    test_reset_mid_op();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
